mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_responder_mem_array.sv | 35 +++
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder and its RAM.
package mem_responder_pkg;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;
endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM; the read register only updates on re so it can
// double as the responder's held read-data output.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory slave: captures a Read/Write strobe, waits WAIT_CYCLES,
// performs the access and holds MFC until the strobe drops.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] Mdatain,
    output logic              MFC,
    output logic              busy,
    output logic              err,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              strobe;

    assign strobe = (op_q == OP_WRITE) ? Write : Read;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = data_q;

        unique case (state_q)
            IDLE: begin
                ram_addr  = init_addr;
                ram_wdata = init_data;
                if (Read && Write) begin
                    err_d = 1'b1;
                end else if (Read || Write) begin
                    op_d    = Write ? OP_WRITE : OP_READ;
                    addr_d  = address;
                    data_d  = data_in;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = WAIT;
                end else if (init_we) begin
                    ram_we = 1'b1;
                end
            end
            // Counter hits zero WAIT_CYCLES edges after capture; the access
            // happens on the following edge, giving WAIT_CYCLES+1 latency.
            WAIT: begin
                if (!strobe) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    ram_we  = (op_q == OP_WRITE);
                    ram_re  = (op_q == OP_READ);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (!strobe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clock(clock),
        .clear(clear),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(Mdatain)
    );

    assign MFC  = (state_q == DONE);
    assign busy = (state_q != IDLE);
    assign err  = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, each
// tracked by a transaction-level model compared every cycle, plus directed checks.
module tb_mem_responder;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int NW = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr [2];
    logic          rd  [2];
    logic          wr  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] din [2];
    logic          iwe [2];
    logic [AW-1:0] iad [2];
    logic [DW-1:0] idt [2];
    logic [DW-1:0] mdo [2];
    logic          mfc [2];
    logic          bsy [2];
    logic          erro[2];

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut0 (
        .clock(clk), .clear(clr[0]), .Read(rd[0]), .Write(wr[0]),
        .address(adr[0]), .data_in(din[0]), .Mdatain(mdo[0]), .MFC(mfc[0]),
        .busy(bsy[0]), .err(erro[0]), .init_we(iwe[0]), .init_addr(iad[0]),
        .init_data(idt[0])
    );

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut1 (
        .clock(clk), .clear(clr[1]), .Read(rd[1]), .Write(wr[1]),
        .address(adr[1]), .data_in(din[1]), .Mdatain(mdo[1]), .MFC(mfc[1]),
        .busy(bsy[1]), .err(erro[1]), .init_we(iwe[1]), .init_addr(iad[1]),
        .init_data(idt[1])
    );

    int errors = 0;
    int checks = 0;

    function automatic int wcv(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic [DW-1:0] pre(input int a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a request is captured, completes WAIT+1 edges later unless its
    // strobe drops first, then MFC holds until the strobe drops.
    int            ph   [2];
    int            due  [2];
    bit            mop  [2];
    logic [AW-1:0] madr [2];
    logic [DW-1:0] mdi  [2];
    logic [DW-1:0] mmd  [2];
    bit            merr [2];
    logic [DW-1:0] mm   [2][NW];
    int            cyc = 0;

    task automatic model_step(input int k);
        bit s;
        s = mop[k] ? wr[k] : rd[k];
        if (clr[k]) begin
            ph[k] = 0; mmd[k] = '0; merr[k] = 1'b0;
        end else if (ph[k] == 0) begin
            if (rd[k] && wr[k]) begin
                merr[k] = 1'b1;
            end else if (rd[k] || wr[k]) begin
                mop[k] = wr[k]; madr[k] = adr[k]; mdi[k] = din[k];
                due[k] = cyc + wcv(k) + 1; ph[k] = 1;
            end else if (iwe[k]) begin
                mm[k][iad[k]] = idt[k];
            end
        end else if (ph[k] == 1) begin
            if (!s) begin
                ph[k] = 0;
            end else if (cyc == due[k]) begin
                if (mop[k]) mm[k][madr[k]] = mdi[k];
                else        mmd[k] = mm[k][madr[k]];
                ph[k] = 2;
                $display("inst%0d %s addr=%03h data=%08h", k, mop[k] ? "write" : "read ",
                         madr[k], mop[k] ? mdi[k] : mmd[k]);
            end
        end else if (!s) begin
            ph[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d_mfc", k),     {31'd0, mfc[k]},  {31'd0, ph[k] == 2});
            chk($sformatf("i%0d_busy", k),    {31'd0, bsy[k]},  {31'd0, ph[k] != 0});
            chk($sformatf("i%0d_err", k),     {31'd0, erro[k]}, {31'd0, merr[k]});
            chk($sformatf("i%0d_mdatain", k), mdo[k], mmd[k]);
        end
    end

    // Returns edges counted from the capture edge to the first MFC (99 on timeout).
    task automatic wait_mfc(input int k, output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (mfc[k]) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic do_op(input int k, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] q);
        int n;
        @(negedge clk);
        rd[k] = !w; wr[k] = w; adr[k] = a; din[k] = d;
        wait_mfc(k, n);
        chk($sformatf("i%0d_latency", k), 32'(n - 1), 32'(wcv(k) + 1));
        q = mdo[k];
        @(negedge clk);
        rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    task automatic rand_drive(input int k, input int ncyc);
        int r;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            clr[k] = ($urandom_range(0, 99) == 0);
            iwe[k] = ($urandom_range(0, 3) == 0);
            iad[k] = 9'($urandom_range(0, 31));
            idt[k] = $urandom;
            if (rd[k] || wr[k]) begin
                if (mfc[k] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0)) begin
                    rd[k] = 1'b0; wr[k] = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    adr[k] = 9'($urandom_range(0, 31));
                    din[k] = $urandom;
                end
            end else begin
                r = $urandom_range(0, 19);
                adr[k] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, NW - 1))
                                                     : 9'($urandom_range(0, 31));
                din[k] = $urandom;
                rd[k] = (r < 7) || (r == 14);
                wr[k] = (r >= 7 && r < 15);
            end
        end
        @(negedge clk);
        rd[k] = 1'b0; wr[k] = 1'b0; iwe[k] = 1'b0; clr[k] = 1'b0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] q;
        for (int k = 0; k < 2; k++) begin
            clr[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; adr[k] = '0; din[k] = '0;
            iwe[k] = 1'b0; iad[k] = '0; idt[k] = '0;
            ph[k] = 0; due[k] = 0; mop[k] = 1'b0; madr[k] = '0; mdi[k] = '0;
            mmd[k] = '0; merr[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            clr[k] = 1'b0;
            chk($sformatf("i%0d_rst_mfc", k),  {31'd0, mfc[k]},  32'd0);
            chk($sformatf("i%0d_rst_busy", k), {31'd0, bsy[k]},  32'd0);
            chk($sformatf("i%0d_rst_err", k),  {31'd0, erro[k]}, 32'd0);
            chk($sformatf("i%0d_rst_md", k),   mdo[k], 32'd0);
        end

        // Back-door preload of both arrays.
        for (int a = 0; a < NW; a++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                iwe[k] = 1'b1; iad[k] = 9'(a); idt[k] = pre(a);
            end
        end
        @(negedge clk);
        iad[0] = 9'h010; idt[0] = 32'h0880_0000; iwe[1] = 1'b0;
        @(negedge clk);
        iwe[0] = 1'b0;

        // Read of preloaded program word: 3-cycle latency, busy until release.
        rd[0] = 1'b1; adr[0] = 9'h010;
        wait_mfc(0, n);
        chk("t1_latency", 32'(n - 1), 32'd3);
        chk("t1_data", mdo[0], 32'h0880_0000);
        chk("t1_busy", {31'd0, bsy[0]}, 32'd1);
        @(negedge clk); rd[0] = 1'b0;
        @(posedge clk); #1;
        chk("t1_mfc_drop", {31'd0, mfc[0]}, 32'd0);
        chk("t1_busy_drop", {31'd0, bsy[0]}, 32'd0);

        // Write then read back; neighbour untouched.
        do_op(0, 1'b1, 9'h05A, 32'hDEAD_BEEF, q);
        do_op(0, 1'b0, 9'h05A, 32'h0, q);
        chk("t2_readback", q, 32'hDEAD_BEEF);
        do_op(0, 1'b0, 9'h05B, 32'h0, q);
        chk("t2_neighbour", q, pre(9'h05B));

        // Zero-wait instance: one-edge latency, MFC and data stable while held.
        @(negedge clk); rd[1] = 1'b1; adr[1] = 9'h000;
        wait_mfc(1, n);
        chk("t3_latency", 32'(n - 1), 32'd1);
        chk("t3_data", mdo[1], pre(0));
        repeat (4) begin
            @(posedge clk); #1;
            chk("t3_mfc_hold", {31'd0, mfc[1]}, 32'd1);
            chk("t3_data_hold", mdo[1], pre(0));
        end
        @(negedge clk); rd[1] = 1'b0;

        // Write aborted after one cycle in WAIT.
        @(negedge clk); wr[0] = 1'b1; adr[0] = 9'h020; din[0] = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk); wr[0] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("t4_no_mfc", {31'd0, mfc[0]}, 32'd0);
        end
        do_op(0, 1'b0, 9'h020, 32'h0, q);
        chk("t4_old_value", q, pre(9'h020));

        // Read/Write collision: sticky err, no access.
        @(negedge clk); rd[0] = 1'b1; wr[0] = 1'b1; adr[0] = 9'h030; din[0] = 32'hFFFF_0000;
        repeat (4) begin
            @(posedge clk); #1;
            chk("t5_err", {31'd0, erro[0]}, 32'd1);
            chk("t5_no_mfc", {31'd0, mfc[0]}, 32'd0);
        end
        @(negedge clk); rd[0] = 1'b0; wr[0] = 1'b0;
        do_op(0, 1'b0, 9'h030, 32'h0, q);
        chk("t5_mem_unchanged", q, pre(9'h030));
        chk("t5_err_sticky", {31'd0, erro[0]}, 32'd1);
        do_op(0, 1'b1, 9'h031, 32'h0BAD_F00D, q);
        chk("t5_err_sticky2", {31'd0, erro[0]}, 32'd1);

        // clear during a write's WAIT; back-door write while busy ignored.
        do_op(0, 1'b0, 9'h05A, 32'h0, q);
        @(negedge clk); wr[0] = 1'b1; adr[0] = 9'h040; din[0] = 32'hCAFE_F00D;
        @(negedge clk); iwe[0] = 1'b1; iad[0] = 9'h041; idt[0] = 32'h1111_1111;
        @(negedge clk); clr[0] = 1'b1; wr[0] = 1'b0; iwe[0] = 1'b0;
        @(posedge clk); #1;
        chk("t6_mfc", {31'd0, mfc[0]}, 32'd0);
        chk("t6_busy", {31'd0, bsy[0]}, 32'd0);
        chk("t6_mdatain", mdo[0], 32'd0);
        chk("t6_err", {31'd0, erro[0]}, 32'd0);
        @(negedge clk); clr[0] = 1'b0;
        do_op(0, 1'b0, 9'h040, 32'h0, q);
        chk("t6_target", q, pre(9'h040));
        do_op(0, 1'b0, 9'h041, 32'h0, q);
        chk("t6_init_ignored", q, pre(9'h041));

        fork
            rand_drive(0, 3000);
            rand_drive(1, 3000);
        join
        repeat (4) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
